// File: rtl/multi_sel_rx.sv
// Receive-side decoder for the multi_sel stream: tracks 4-word frames (d, 3d, 7d, 9d),
// recovers the base byte, flags the first failing word and keeps a saturating error count.
module multi_sel_rx #(
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_grant,
   input  logic [10:0]          in_data,
   output logic [7:0]           d_out,
   output logic                 d_valid,
   output logic                 frame_err,
   output logic [1:0]           err_idx,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   typedef enum logic [1:0] {IDLE, W1, W2, W3} state_t;

   state_t               state_q, state_d;
   logic [7:0]           base_q, base_d;
   logic                 bad_q, bad_d;
   logic [1:0]           fidx_q, fidx_d;
   logic [7:0]           d_out_q, d_out_d;
   logic                 d_valid_q, d_valid_d;
   logic                 frame_err_q, frame_err_d;
   logic [1:0]           err_idx_q, err_idx_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic [11:0]          base_ext;
   logic [11:0]          prod;
   logic [1:0]           word_idx;
   logic                 mismatch;
   logic                 cnt_inc;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         base_q      <= '0;
         bad_q       <= 1'b0;
         fidx_q      <= '0;
         d_out_q     <= '0;
         d_valid_q   <= 1'b0;
         frame_err_q <= 1'b0;
         err_idx_q   <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         bad_q       <= bad_d;
         fidx_q      <= fidx_d;
         d_out_q     <= d_out_d;
         d_valid_q   <= d_valid_d;
         frame_err_q <= frame_err_d;
         err_idx_q   <= err_idx_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      bad_d       = bad_q;
      fidx_d      = fidx_q;
      d_out_d     = d_out_q;
      d_valid_d   = 1'b0;
      frame_err_d = 1'b0;
      err_idx_d   = err_idx_q;
      cnt_inc     = 1'b0;
      base_ext    = {4'b0000, base_q};
      prod        = '0;
      word_idx    = '0;

      // Expected multiple for the current word, computed in 12 bits then cut to 11
      unique case (state_q)
         W1:      begin prod = base_ext * 12'd3; word_idx = 2'd1; end
         W2:      begin prod = base_ext * 12'd7; word_idx = 2'd2; end
         W3:      begin prod = base_ext * 12'd9; word_idx = 2'd3; end
         default: ;
      endcase
      mismatch = (in_data != prod[10:0]);

      if (in_grant) begin
         if (state_q != IDLE) begin
            frame_err_d = 1'b1;
            err_idx_d   = word_idx;
            cnt_inc     = 1'b1;
         end
         base_d  = in_data[7:0];
         bad_d   = |in_data[10:8];
         fidx_d  = '0;
         state_d = W1;
      end else if (state_q != IDLE) begin
         if (mismatch && !bad_q) begin
            bad_d  = 1'b1;
            fidx_d = word_idx;
         end
         if (state_q == W1) begin
            state_d = W2;
         end else if (state_q == W2) begin
            state_d = W3;
         end else begin
            state_d = IDLE;
            if (bad_d) begin
               frame_err_d = 1'b1;
               err_idx_d   = fidx_d;
               cnt_inc     = 1'b1;
            end else begin
               d_valid_d = 1'b1;
               d_out_d   = base_q;
            end
         end
      end

      err_cnt_d = (cnt_inc && (err_cnt_q != '1)) ? err_cnt_q + ERR_CNT_W'(1) : err_cnt_q;
   end

   assign d_out     = d_out_q;
   assign d_valid   = d_valid_q;
   assign frame_err = frame_err_q;
   assign err_idx   = err_idx_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_multi_sel_rx.sv
// Scoreboard bench for multi_sel_rx: a word-list frame model pushes expected results,
// a negedge monitor pops and compares them against the DUT pulses.
module tb_multi_sel_rx;

   localparam int W    = 8;
   localparam int CMAX = (1 << W) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_grant;
   logic [10:0]   in_data;
   logic [7:0]    d_out;
   logic          d_valid;
   logic          frame_err;
   logic [1:0]    err_idx;
   logic [W-1:0]  err_cnt;

   multi_sel_rx #(.ERR_CNT_W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_grant  (in_grant),
      .in_data   (in_data),
      .d_out     (d_out),
      .d_valid   (d_valid),
      .frame_err (frame_err),
      .err_idx   (err_idx),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      bit is_err;
      int dout;
      int idx;
      int cnt;
   } ev_t;

   ev_t q[$];
   int  checks = 0;
   int  errors = 0;

   // Reference model: words of the frame in progress plus held output values
   int m_words[$];
   int m_cnt  = 0;
   int m_dout = 0;
   int m_idx  = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input bit is_err);
      ev_t e;
      e.cyc    = cyc + 1;
      e.is_err = is_err;
      e.dout   = m_dout;
      e.idx    = m_idx;
      e.cnt    = m_cnt;
      q.push_back(e);
   endtask

   task automatic evaluate();
      int mult[4];
      int base;
      int first;
      mult  = '{1, 3, 7, 9};
      base  = m_words[0] % 256;
      first = -1;
      if (m_words[0] >= 256) first = 0;
      for (int k = 1; k < 4; k++)
         if (first < 0 && m_words[k] != (base * mult[k]) % 2048) first = k;
      if (first < 0) begin
         m_dout = base;
         push(1'b0);
      end else begin
         if (m_cnt < CMAX) m_cnt++;
         m_idx = first;
         push(1'b1);
      end
   endtask

   task automatic model(input bit g, input int w, input bit r);
      if (!r) begin
         m_words.delete();
         m_cnt  = 0;
         m_dout = 0;
         m_idx  = 0;
      end else if (g) begin
         if (m_words.size() != 0) begin
            if (m_cnt < CMAX) m_cnt++;
            m_idx = m_words.size();
            push(1'b1);
         end
         m_words.delete();
         m_words.push_back(w);
      end else if (m_words.size() != 0) begin
         m_words.push_back(w);
         if (m_words.size() == 4) begin
            evaluate();
            m_words.delete();
         end
      end
   endtask

   task automatic drive(input bit g, input int w, input bit r);
      @(posedge clk);
      #1;
      rst      = r;
      in_grant = g;
      in_data  = 11'(w);
      model(g, w, r);
   endtask

   task automatic word(input bit g, input int w);
      drive(g, w, 1'b1);
   endtask

   task automatic frame(input int a, input int b, input int c, input int d);
      word(1'b1, a);
      word(1'b0, b);
      word(1'b0, c);
      word(1'b0, d);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_d_out"},     int'(d_out),     0);
      chk({tag, "_d_valid"},   int'(d_valid),   0);
      chk({tag, "_frame_err"}, int'(frame_err), 0);
      chk({tag, "_err_idx"},   int'(err_idx),   0);
      chk({tag, "_err_cnt"},   int'(err_cnt),   0);
   endtask

   always @(negedge clk) begin
      ev_t e;
      while (q.size() > 0 && q[0].cyc < cyc) begin
         checks++;
         errors++;
         $display("FAIL missing_pulse: expected at cycle %0d, not observed by cycle %0d", q[0].cyc, cyc);
         void'(q.pop_front());
      end
      if (d_valid === 1'b1 || frame_err === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: d_valid=%0b frame_err=%0b expected none (cycle %0d)",
                     d_valid, frame_err, cyc);
         end else begin
            e = q.pop_front();
            chk("pulse_cycle", cyc, e.cyc);
            chk("exclusive",   int'(d_valid & frame_err), 0);
            chk("frame_err",   int'(frame_err), int'(e.is_err));
            chk("d_out",       int'(d_out),     e.dout);
            chk("err_idx",     int'(err_idx),   e.idx);
            chk("err_cnt",     int'(err_cnt),   e.cnt);
         end
      end
   end

   initial begin
      int b;
      int len;
      int ws[4];
      rst      = 1'b0;
      in_grant = 1'b0;
      in_data  = '0;
      model(1'b0, 0, 1'b0);
      drive(1'b0, 0, 1'b0);
      drive(1'b1, 5, 1'b0);
      word(1'b0, 0);
      chk_reset_outputs("reset");

      frame(5, 15, 35, 45);
      frame(255, 765, 1785, 247);
      frame(255, 765, 1785, 2047);
      frame(10, 30, 71, 91);
      word(1'b0, 0);
      word(1'b1, 10);
      word(1'b0, 30);
      frame(20, 60, 140, 180);
      frame(12'h105, 15, 35, 45);
      word(1'b1, 3);
      word(1'b1, 4);
      word(1'b0, 12);
      word(1'b1, 6);
      frame(6, 18, 42, 54);
      word(1'b0, 0);

      for (int n = 0; n < 300; n++) begin
         b  = $urandom_range(0, 255);
         ws = '{b, (b * 3) % 2048, (b * 7) % 2048, (b * 9) % 2048};
         for (int k = 0; k < 4; k++)
            if ($urandom_range(0, 5) == 0) ws[k] = ws[k] ^ (1 << $urandom_range(0, 10));
         len = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 4;
         for (int k = 0; k < len; k++) word(k == 0, ws[k]);
         if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 2)) word(1'b0, $urandom_range(0, 2047));
      end

      repeat (260) frame(10, 31, 70, 90);
      frame(1, 3, 7, 9);
      word(1'b0, 0);

      word(1'b1, 7);
      word(1'b0, 21);
      drive(1'b1, 12'h55, 1'b0);
      word(1'b0, 0);
      chk_reset_outputs("midframe_reset");
      word(1'b0, 14);
      word(1'b0, 0);
      frame(2, 6, 14, 18);

      repeat (8) word(1'b0, 0);
      @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
